// File: rtl/s32x_sdr_responder_pkg.sv
// Shared types and constants for the SH2 SDRAM-bus responder.
package s32x_sdr_responder_pkg;

  typedef logic [2:0] sdr_state_t;

  localparam sdr_state_t ST_IDLE   = 3'd0;
  localparam sdr_state_t ST_WFLUSH = 3'd1;
  localparam sdr_state_t ST_RD_REQ = 3'd2;
  localparam sdr_state_t ST_PF_REQ = 3'd3;
  localparam sdr_state_t ST_DONE   = 3'd4;

  localparam logic [1:0] BE_WORD = 2'b11;

  // Posted-write buffer payload; the address lives beside it because its width is a module parameter.
  typedef struct packed {
    logic        valid;
    logic [1:0]  be;
    logic [15:0] data;
  } wbuf_t;

endpackage

// File: rtl/s32x_sdr_responder.sv
// SH2 SDRAM-bus target: posted single-entry write buffer, one-word read-ahead,
// and a req/ack memory port. SDR_WAIT stalls the bus until the access is served.
module s32x_sdr_responder
  import s32x_sdr_responder_pkg::*;
#(
  parameter int PREFETCH = 1,
  parameter int AW       = 17
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] SDR_A,
  input  logic [15:0]   SDR_DO,
  input  logic          SDR_CS,
  input  logic [1:0]    SDR_WE,
  input  logic          SDR_RD,
  output logic [15:0]   SDR_DI,
  output logic          SDR_WAIT,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [1:0]    MEM_BE,
  output logic [15:0]   MEM_DOUT,
  input  logic          MEM_ACK,
  input  logic [15:0]   MEM_DIN
);

  localparam int KW = AW + 3;

  logic          act;
  logic          is_wr;
  logic          live;
  logic          done_eff;
  logic          ra_hit;
  logic          pf_needed;
  logic [KW-1:0] key;
  logic [AW-1:0] pf_addr;

  sdr_state_t    state_q, state_d;
  logic          done_q, done_d;
  logic          act_q, act_d;
  logic [KW-1:0] key_q, key_d;
  wbuf_t         wb_q, wb_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic          ra_valid_q, ra_valid_d;
  logic [AW-1:0] ra_tag_q, ra_tag_d;
  logic [15:0]   ra_data_q, ra_data_d;
  logic          last_rd_q, last_rd_d;
  logic [AW-1:0] last_a_q, last_a_d;
  logic          rd_abort_q, rd_abort_d;
  logic [15:0]   sdr_di_q, sdr_di_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic [15:0]   mem_dout_q, mem_dout_d;

  assign act   = SDR_CS & (SDR_RD | (|SDR_WE));
  assign is_wr = |SDR_WE;
  assign key   = {SDR_A, SDR_WE, SDR_RD};

  // The same access continues only while ACT stays high with an unchanged key.
  assign live      = act & act_q & (key == key_q);
  assign done_eff  = done_q & live;
  assign SDR_WAIT  = act & ~done_eff;

  assign ra_hit    = ra_valid_q & (ra_tag_q == SDR_A);
  assign pf_addr   = last_a_q + AW'(1);
  assign pf_needed = (PREFETCH != 0) & last_rd_q & ~(ra_valid_q & (ra_tag_q == pf_addr));

  assign SDR_DI    = sdr_di_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_DOUT  = mem_dout_q;

  always_comb begin
    state_d    = state_q;
    done_d     = done_eff;
    act_d      = act;
    key_d      = key;
    wb_d       = wb_q;
    wb_addr_d  = wb_addr_q;
    ra_valid_d = ra_valid_q;
    ra_tag_d   = ra_tag_q;
    ra_data_d  = ra_data_q;
    last_rd_d  = last_rd_q;
    last_a_d   = last_a_q;
    rd_abort_d = rd_abort_q;
    sdr_di_d   = sdr_di_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d   = mem_be_q;
    mem_dout_d = mem_dout_q;

    case (state_q)
      ST_IDLE: begin
        // A pending write always retires first: keeps reads ordered and drains in the background.
        if (wb_q.valid) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = wb_addr_q;
          mem_be_d   = wb_q.be;
          mem_dout_d = wb_q.data;
          state_d    = ST_WFLUSH;
        end else if (act && !done_eff) begin
          if (is_wr) begin
            wb_d.valid = 1'b1;
            wb_d.be    = SDR_WE;
            wb_d.data  = SDR_DO;
            wb_addr_d  = SDR_A;
            ra_valid_d = 1'b0;
            last_rd_d  = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else if (ra_hit) begin
            sdr_di_d   = ra_data_q;
            last_rd_d  = 1'b1;
            last_a_d   = SDR_A;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = SDR_A;
            mem_be_d   = BE_WORD;
            rd_abort_d = 1'b0;
            state_d    = ST_RD_REQ;
          end
        end
      end

      ST_WFLUSH: begin
        if (MEM_ACK) begin
          mem_req_d  = 1'b0;
          wb_d.valid = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_RD_REQ: begin
        rd_abort_d = rd_abort_q | ~live;
        if (MEM_ACK) begin
          mem_req_d = 1'b0;
          // Data for an abandoned access is dropped; SDR_DI keeps its last value.
          if (live && !rd_abort_q) begin
            sdr_di_d  = MEM_DIN;
            last_rd_d = 1'b1;
            last_a_d  = mem_addr_q;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end

      ST_DONE: begin
        if (live) begin
          done_d = 1'b1;
        end else if (pf_needed) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pf_addr;
          mem_be_d   = BE_WORD;
          state_d    = ST_PF_REQ;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_PF_REQ: begin
        if (MEM_ACK) begin
          mem_req_d  = 1'b0;
          ra_valid_d = 1'b1;
          ra_tag_d   = mem_addr_q;
          ra_data_d  = MEM_DIN;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      act_q      <= 1'b0;
      wb_q       <= '0;
      ra_valid_q <= 1'b0;
      last_rd_q  <= 1'b0;
      rd_abort_q <= 1'b0;
      sdr_di_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q   <= '0;
      mem_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      act_q      <= act_d;
      wb_q       <= wb_d;
      ra_valid_q <= ra_valid_d;
      last_rd_q  <= last_rd_d;
      rd_abort_q <= rd_abort_d;
      sdr_di_q   <= sdr_di_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
      mem_dout_q <= mem_dout_d;
    end
  end

  // Payload registers are qualified by the valid/act flags above and need no reset.
  always_ff @(posedge CLK) begin
    key_q     <= key_d;
    wb_addr_q <= wb_addr_d;
    ra_tag_q  <= ra_tag_d;
    ra_data_q <= ra_data_d;
    last_a_q  <= last_a_d;
  end

endmodule

// File: tb/tb_s32x_sdr_responder.sv
// Randomized bench for s32x_sdr_responder against a transaction-level model of memory and read-ahead.
module tb_s32x_sdr_responder;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW-1:0] SDR_A = '0;
  logic [15:0]   SDR_DO = '0;
  logic          SDR_CS = 1'b0;
  logic [1:0]    SDR_WE = '0;
  logic          SDR_RD = 1'b0;
  logic [15:0]   SDR_DI;
  logic          SDR_WAIT;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [1:0]    MEM_BE;
  logic [15:0]   MEM_DOUT;
  logic          MEM_ACK = 1'b0;
  logic [15:0]   MEM_DIN = '0;

  s32x_sdr_responder #(.PREFETCH(1), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SDR_A(SDR_A), .SDR_DO(SDR_DO), .SDR_CS(SDR_CS), .SDR_WE(SDR_WE), .SDR_RD(SDR_RD),
    .SDR_DI(SDR_DI), .SDR_WAIT(SDR_WAIT),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_DOUT(MEM_DOUT), .MEM_ACK(MEM_ACK), .MEM_DIN(MEM_DIN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [15:0]   data;
  } mreq_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem     [DEPTH];
  logic [15:0] ref_mem [DEPTH];
  mreq_t       log_q[$];
  mreq_t       exp_q[$];
  int          mem_lat = 3;

  // Reference state: read-ahead contents and last value handed to the bus.
  bit            ra_v = 0;
  logic [AW-1:0] ra_tag = '0;
  logic [15:0]   last_di = '0;
  logic [AW-1:0] touched[$];

  // Memory: ACK on the mem_lat-th cycle REQ is seen high; requests are logged in arrival order.
  int    mcnt = 0;
  mreq_t cur;
  always @(negedge CLK) begin
    if (!RST_N) begin
      MEM_ACK = 1'b0;
      mcnt = 0;
    end else if (MEM_ACK) begin
      MEM_ACK = 1'b0;
      mcnt = 0;
    end else if (MEM_REQ) begin
      if (mcnt == 0) begin
        cur = '{MEM_WE, MEM_ADDR, MEM_BE, MEM_DOUT};
        log_q.push_back(cur);
      end else begin
        chk("req_stable", {12'b0, MEM_WE, MEM_BE, MEM_ADDR}, {12'b0, cur.we, cur.be, cur.addr});
      end
      if (mcnt == mem_lat - 1) begin
        MEM_ACK = 1'b1;
        if (cur.we) begin
          if (cur.be[1]) mem[cur.addr][15:8] = cur.data[15:8];
          if (cur.be[0]) mem[cur.addr][7:0]  = cur.data[7:0];
        end else begin
          MEM_DIN = mem[cur.addr];
        end
      end
      mcnt++;
    end
  end

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return AW'((int'(a) + 1) % DEPTH);
  endfunction

  task automatic access(input logic [AW-1:0] a, input logic [1:0] we, input logic [15:0] d,
                        input int hold, input bit drop, output int waits);
    @(negedge CLK);
    SDR_CS = 1'b1; SDR_A = a; SDR_WE = we; SDR_RD = (we == 2'b00); SDR_DO = d;
    waits = 0;
    #1;
    while (SDR_WAIT && waits < 300) begin
      waits++;
      @(negedge CLK);
      #1;
    end
    if (waits >= 300) chk("wait_timeout", 1, 0);
    repeat (hold) @(negedge CLK);
    if (drop) begin
      @(negedge CLK);
      SDR_CS = 1'b0; SDR_WE = 2'b00; SDR_RD = 1'b0;
    end
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 400) begin
      @(negedge CLK);
      n++;
      if (MEM_REQ) quiet = 0; else quiet++;
    end
    if (quiet < 4) chk("settle_timeout", 1, 0);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_nreq"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, "_req"}, {12'b0, log_q[i].we, log_q[i].be, log_q[i].addr},
          {12'b0, exp_q[i].we, exp_q[i].be, exp_q[i].addr});
      if (exp_q[i].we) chk({tag, "_wdata"}, log_q[i].data, exp_q[i].data);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  // Expected memory traffic for a read that is served: demand fetch on a miss, then fetch-ahead.
  task automatic model_read(input logic [AW-1:0] a, output bit hit);
    hit = ra_v && (ra_tag == a);
    if (!hit) exp_q.push_back('{1'b0, a, 2'b11, 16'h0});
    if (!(ra_v && ra_tag == next_addr(a))) begin
      exp_q.push_back('{1'b0, next_addr(a), 2'b11, 16'h0});
      ra_v = 1;
      ra_tag = next_addr(a);
    end
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [1:0] we, input logic [15:0] d);
    exp_q.push_back('{1'b1, a, we, d});
    if (we[1]) ref_mem[a][15:8] = d[15:8];
    if (we[0]) ref_mem[a][7:0]  = d[7:0];
    ra_v = 0;
    touched.push_back(a);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold, input string tag);
    int w;
    bit hit;
    model_read(a, hit);
    access(a, 2'b00, 16'($urandom), hold, 1, w);
    chk({tag, "_wait"}, w, hit ? 1 : mem_lat + 2);
    chk({tag, "_di"}, SDR_DI, ref_mem[a]);
    last_di = ref_mem[a];
    settle();
    cmp_log(tag);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [1:0] we, input logic [15:0] d,
                          input int hold, input string tag);
    int w;
    model_write(a, we, d);
    access(a, we, d, hold, 1, w);
    chk({tag, "_wait"}, w, 1);
    settle();
    cmp_log(tag);
  endtask

  // Demand read abandoned k cycles in (k <= mem_lat): fetched data is discarded, no fetch-ahead.
  task automatic do_abort(input logic [AW-1:0] a, input int k, input string tag);
    exp_q.push_back('{1'b0, a, 2'b11, 16'h0});
    @(negedge CLK);
    SDR_CS = 1'b1; SDR_A = a; SDR_WE = 2'b00; SDR_RD = 1'b1;
    repeat (k) @(negedge CLK);
    SDR_CS = 1'b0; SDR_RD = 1'b0;
    settle();
    chk({tag, "_di_held"}, SDR_DI, last_di);
    cmp_log(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w1, w2, r, hold;
    bit hit;
    logic [AW-1:0] a;
    logic [1:0] we;
    logic [15:0] d;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 16'((i * 40503) ^ 16'h5A3C);
      ref_mem[i] = mem[i];
    end
    mem[17'h10] = 16'h1234; ref_mem[17'h10] = 16'h1234;
    mem[17'h11] = 16'hBEEF; ref_mem[17'h11] = 16'hBEEF;

    repeat (3) @(negedge CLK);
    chk("rst_di", SDR_DI, 0);
    chk("rst_req", MEM_REQ, 0);
    chk("rst_wait", SDR_WAIT, 0);
    chk("rst_mem_fields", {MEM_WE, MEM_BE, MEM_ADDR}, 0);
    chk("rst_dout", MEM_DOUT, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    mem_lat = 3;
    do_read(17'h00010, 0, "t1_rd_miss");
    do_read(17'h00011, 0, "t2_rd_hit");

    mem_lat = 4;
    do_write(17'h00020, 2'b10, 16'h5A5A, 0, "t3_bytewr");
    model_write(17'h00021, 2'b11, 16'h1357);
    model_write(17'h00022, 2'b01, 16'h2468);
    access(17'h00021, 2'b11, 16'h1357, 0, 1, w1);
    access(17'h00022, 2'b01, 16'h2468, 0, 1, w2);
    chk("t3_wr1_wait", w1, 1);
    chk("t3_wr2_stalled", (w2 >= mem_lat + 1), 1);
    settle();
    cmp_log("t3_wr_pair");

    mem_lat = 3;
    do_read(17'h00010, 0, "t4_prime");
    model_write(17'h00011, 2'b11, 16'hC3A5);
    access(17'h00011, 2'b11, 16'hC3A5, 0, 0, w1);
    model_read(17'h00011, hit);
    access(17'h00011, 2'b00, 16'h0, 0, 1, w2);
    chk("t4_di", SDR_DI, 16'hC3A5);
    chk("t4_no_hit", hit, 0);
    last_di = 16'hC3A5;
    settle();
    cmp_log("t4_order");

    do_read(17'h1FFFF, 1, "t5_wrap");
    do_abort(17'h00030, 1, "t5_abort");

    do_read(17'h00050, 0, "t6_prime");
    mem_lat = 4;
    exp_q.push_back('{1'b0, 17'h00040, 2'b11, 16'h0});
    @(negedge CLK);
    SDR_CS = 1'b1; SDR_A = 17'h00040; SDR_WE = 2'b00; SDR_RD = 1'b1;
    repeat (2) @(negedge CLK);
    chk("t6_req_inflight", MEM_REQ, 1);
    RST_N = 1'b0; SDR_CS = 1'b0; SDR_RD = 1'b0;
    @(negedge CLK);
    chk("t6_req_dropped", MEM_REQ, 0);
    chk("t6_wait", SDR_WAIT, 0);
    chk("t6_di", SDR_DI, 0);
    chk("t6_mem_fields", {MEM_WE, MEM_BE, MEM_ADDR}, 0);
    RST_N = 1'b1;
    ra_v = 0;
    last_di = '0;
    repeat (3) @(negedge CLK);
    chk("t6_quiet", MEM_REQ, 0);
    cmp_log("t6_reset_req");
    mem_lat = 2;
    do_read(17'h00051, 0, "t6_ra_cleared");

    for (int it = 0; it < 80; it++) begin
      mem_lat = $urandom_range(1, 4);
      a = AW'((32'h1FFF8 + $urandom_range(0, 15)) % DEPTH);
      hold = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      if (r < 40) begin
        case ($urandom_range(0, 2))
          0: we = 2'b01;
          1: we = 2'b10;
          default: we = 2'b11;
        endcase
        d = 16'($urandom);
        do_write(a, we, d, hold, "rnd_wr");
      end else if (r < 85 || (ra_v && ra_tag == a)) begin
        do_read(a, hold, "rnd_rd");
      end else begin
        do_abort(a, $urandom_range(1, mem_lat), "rnd_abort");
      end
    end

    foreach (touched[i]) chk("final_mem", mem[touched[i]], ref_mem[touched[i]]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
